// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller signal bundle.
// Buttons and counter-chain status in, counter-chain controls out.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lr;
    logic       cnt_full;
    logic       cnt_en;
    logic       cnt_clr;
    logic       lap_load;
    logic       disp_freeze;
    logic [1:0] state;

    modport master (
        output btn_ss,
        output btn_lr,
        output cnt_full,
        input  cnt_en,
        input  cnt_clr,
        input  lap_load,
        input  disp_freeze,
        input  state
    );

    modport slave (
        input  btn_ss,
        input  btn_lr,
        input  cnt_full,
        output cnt_en,
        output cnt_clr,
        output lap_load,
        output disp_freeze,
        output state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button sync/debounce, tick prescaler,
// run/pause/lap/clear sequencing for an external BCD counter chain.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 10,
    parameter int DB_CYC  = 2000000
) (
    input  logic          clk,
    input  logic          rst_n,
    stopwatch_ctrl_if.slave sw
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(DB_CYC + 1);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [CW-1:0] DMAX = CW'(DB_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } st_t;

    logic [1:0]    rs;
    logic          rst_ok;
    logic [1:0]    raw;
    logic [1:0]    b_m;
    logic [1:0]    b_s;
    logic [1:0]    sv;
    logic [1:0]    acc;
    logic [1:0]    prev;
    logic [1:0]    arm;
    logic [CW-1:0] dbc [2];
    logic [1:0]    press;
    logic          ss_p;
    logic          lr_p;

    st_t           state_q;
    st_t           state_n;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_n;
    logic          clr_q;
    logic          clr_n;
    logic          load_q;
    logic          load_n;
    logic          frz_q;
    logic          frz_n;
    logic          running;
    logic          run_n;
    logic          tick;

    assign rst_ok = rs[1];
    assign raw    = {sw.btn_lr, sw.btn_ss};

    // Reset release synchronizer; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs <= 2'b00;
        end else begin
            rs <= {rs[0], 1'b1};
        end
    end

    // Two-flop button synchronizers; sv marks when b_s holds real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_m <= 2'b00;
            b_s <= 2'b00;
            sv  <= 2'b00;
        end else if (rst_ok) begin
            b_m <= raw;
            b_s <= b_m;
            sv  <= {sv[0], 1'b1};
        end
    end

    // Debounce, edge history and re-arm after a released level is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= 2'b00;
            prev   <= 2'b00;
            arm    <= 2'b00;
            dbc[0] <= '0;
            dbc[1] <= '0;
        end else if (rst_ok) begin
            for (int i = 0; i < 2; i++) begin
                if (b_s[i] != acc[i]) begin
                    if (dbc[i] == DMAX) begin
                        acc[i] <= b_s[i];
                        dbc[i] <= '0;
                    end else begin
                        dbc[i] <= dbc[i] + CW'(1);
                    end
                end else begin
                    dbc[i] <= '0;
                end
                if (sv[1] && !b_s[i]) begin
                    arm[i] <= 1'b1;
                end
                prev[i] <= acc[i];
            end
        end
    end

    assign press = acc & ~prev & arm;
    assign ss_p  = press[0];
    assign lr_p  = press[1];

    assign running   = (state_q == RUN) || (state_q == LAP);
    assign tick      = (pre_q == PMAX);
    assign sw.cnt_en = tick & running & ~sw.cnt_full;

    // Next state, one-shot strobes and prescaler next value.
    always_comb begin
        state_n = state_q;
        clr_n   = 1'b0;
        load_n  = 1'b0;
        if (running && tick && sw.cnt_full) begin
            state_n = PAUSE;
        end else if (ss_p) begin
            unique case (state_q)
                IDLE:    state_n = RUN;
                RUN:     state_n = PAUSE;
                LAP:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                default: state_n = IDLE;
            endcase
        end else if (lr_p) begin
            unique case (state_q)
                IDLE:    state_n = IDLE;
                RUN: begin
                    state_n = LAP;
                    load_n  = 1'b1;
                end
                LAP:     state_n = RUN;
                PAUSE: begin
                    state_n = IDLE;
                    clr_n   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
        run_n = (state_n == RUN) || (state_n == LAP);
        frz_n = (state_n == LAP);
        pre_n = '0;
        if (running && run_n) begin
            pre_n = tick ? '0 : pre_q + PW'(1);
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
            frz_q   <= 1'b0;
        end else if (rst_ok) begin
            state_q <= state_n;
            pre_q   <= pre_n;
            clr_q   <= clr_n;
            load_q  <= load_n;
            frz_q   <= frz_n;
        end
    end

    assign sw.state       = state_q;
    assign sw.cnt_clr     = clr_q;
    assign sw.lap_load    = load_q;
    assign sw.disp_freeze = frz_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with a 10-cycle tick and
// 3-cycle debounce; button presses surface 6 cycles after assertion.
module tb_stopwatch_ctrl;

    localparam int P0 = 20;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    typedef struct {
        int         at;
        logic [1:0] st;
        logic       clr;
        logic       load;
        logic       frz;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    ev_t  evq[$];
    int   tkq[$];
    ev_t  e;
    int   t;
    logic [1:0] pst  = 2'b00;
    logic       pfrz = 1'b0;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(
        .CLK_HZ (100),
        .TICK_HZ(10),
        .DB_CYC (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected state/strobe events and tick cycles.
    always @(negedge clk) begin
        if (sw.state != pst || sw.disp_freeze != pfrz ||
            sw.cnt_clr || sw.lap_load) begin
            n_chk++;
            if (evq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d st=%b clr=%b load=%b frz=%b",
                         cyc, sw.state, sw.cnt_clr, sw.lap_load, sw.disp_freeze);
            end else begin
                e = evq.pop_front();
                if (e.at != cyc || e.st != sw.state || e.clr != sw.cnt_clr ||
                    e.load != sw.lap_load || e.frz != sw.disp_freeze) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d st=%b clr=%b load=%b frz=%b want cyc=%0d st=%b clr=%b load=%b frz=%b",
                             cyc, sw.state, sw.cnt_clr, sw.lap_load, sw.disp_freeze,
                             e.at, e.st, e.clr, e.load, e.frz);
                end
            end
        end
        if (sw.cnt_en) begin
            n_chk++;
            if (tkq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cnt_en cyc=%0d", cyc);
            end else begin
                t = tkq.pop_front();
                if (t != cyc) begin
                    n_fail++;
                    $display("FAIL cnt_en got cyc=%0d want cyc=%0d", cyc, t);
                end
            end
        end
        pst  = sw.state;
        pfrz = sw.disp_freeze;
    end

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void exp_ev(input int at, input logic [1:0] st,
                                   input logic clr, input logic load,
                                   input logic frz);
        ev_t x;
        x.at   = at;
        x.st   = st;
        x.clr  = clr;
        x.load = load;
        x.frz  = frz;
        evq.push_back(x);
    endfunction

    function automatic void exp_ticks(input int en, input int ex);
        for (int k = en + 9; k < ex; k += 10) tkq.push_back(k);
    endfunction

    task automatic chk_zero(input string nm);
        n_chk++;
        if ({sw.state, sw.cnt_en, sw.cnt_clr, sw.lap_load, sw.disp_freeze} != 6'b0) begin
            n_fail++;
            $display("FAIL %s got st=%b en=%b clr=%b load=%b frz=%b want all 0",
                     nm, sw.state, sw.cnt_en, sw.cnt_clr, sw.lap_load, sw.disp_freeze);
        end
    endtask

    initial begin
        sw.btn_ss   = 1'b0;
        sw.btn_lr   = 1'b0;
        sw.cnt_full = 1'b0;
        go(2);
        chk_zero("reset_state");
        go(3);
        rst_n = 1'b1;

        // Start, then glitch that must be ignored.
        exp_ev(P0 + 6, S_RUN, 1'b0, 1'b0, 1'b0);
        exp_ticks(P0 + 6, P0 + 76);
        go(P0);      sw.btn_ss = 1'b1;
        go(P0 + 10); sw.btn_ss = 1'b0;
        go(P0 + 20); sw.btn_ss = 1'b1;
        go(P0 + 21); sw.btn_ss = 1'b0;
        go(P0 + 22); sw.btn_ss = 1'b1;
        go(P0 + 23); sw.btn_ss = 1'b0;

        // Lap in, lap out, pause.
        go(P0 + 30);
        exp_ev(P0 + 36, S_LAP, 1'b0, 1'b1, 1'b1);
        sw.btn_lr = 1'b1;
        go(P0 + 40); sw.btn_lr = 1'b0;
        go(P0 + 50);
        exp_ev(P0 + 56, S_RUN, 1'b0, 1'b0, 1'b0);
        sw.btn_lr = 1'b1;
        go(P0 + 60); sw.btn_lr = 1'b0;
        go(P0 + 70);
        exp_ev(P0 + 76, S_PAUSE, 1'b0, 1'b0, 1'b0);
        sw.btn_ss = 1'b1;
        go(P0 + 80); sw.btn_ss = 1'b0;

        // Clear from pause; then both buttons together from pause.
        go(P0 + 90);
        exp_ev(P0 + 96, S_IDLE, 1'b1, 1'b0, 1'b0);
        sw.btn_lr = 1'b1;
        go(P0 + 100); sw.btn_lr = 1'b0;
        go(P0 + 110);
        exp_ev(P0 + 116, S_RUN, 1'b0, 1'b0, 1'b0);
        exp_ticks(P0 + 116, P0 + 136);
        sw.btn_ss = 1'b1;
        go(P0 + 120); sw.btn_ss = 1'b0;
        go(P0 + 130);
        exp_ev(P0 + 136, S_PAUSE, 1'b0, 1'b0, 1'b0);
        sw.btn_ss = 1'b1;
        go(P0 + 140); sw.btn_ss = 1'b0;
        go(P0 + 150);
        exp_ev(P0 + 156, S_RUN, 1'b0, 1'b0, 1'b0);
        exp_ticks(P0 + 156, P0 + 175);
        sw.btn_ss = 1'b1;
        sw.btn_lr = 1'b1;
        go(P0 + 160);
        sw.btn_ss = 1'b0;
        sw.btn_lr = 1'b0;

        // Counter full at tick in RUN beats a simultaneous lap press.
        go(P0 + 170);
        exp_ev(P0 + 176, S_PAUSE, 1'b0, 1'b0, 1'b0);
        sw.btn_lr = 1'b1;
        go(P0 + 174); sw.cnt_full = 1'b1;
        go(P0 + 176); sw.cnt_full = 1'b0;
        go(P0 + 180); sw.btn_lr = 1'b0;

        // Counter full at tick in LAP.
        go(P0 + 190);
        exp_ev(P0 + 196, S_RUN, 1'b0, 1'b0, 1'b0);
        exp_ticks(P0 + 196, P0 + 215);
        sw.btn_ss = 1'b1;
        go(P0 + 200);
        sw.btn_ss = 1'b0;
        exp_ev(P0 + 206, S_LAP, 1'b0, 1'b1, 1'b1);
        sw.btn_lr = 1'b1;
        go(P0 + 210); sw.btn_lr = 1'b0;
        go(P0 + 214);
        exp_ev(P0 + 216, S_PAUSE, 1'b0, 1'b0, 1'b0);
        sw.cnt_full = 1'b1;
        go(P0 + 216); sw.cnt_full = 1'b0;

        // Async reset mid-LAP with buttons held and a press in flight.
        go(P0 + 230);
        exp_ev(P0 + 236, S_RUN, 1'b0, 1'b0, 1'b0);
        exp_ticks(P0 + 236, P0 + 258);
        sw.btn_ss = 1'b1;
        go(P0 + 240);
        sw.btn_ss = 1'b0;
        exp_ev(P0 + 246, S_LAP, 1'b0, 1'b1, 1'b1);
        sw.btn_lr = 1'b1;
        go(P0 + 255); sw.btn_ss = 1'b1;
        go(P0 + 258);
        exp_ev(P0 + 258, S_IDLE, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        go(P0 + 262); rst_n = 1'b1;
        go(P0 + 290);
        sw.btn_ss = 1'b0;
        sw.btn_lr = 1'b0;

        // Fresh presses after release work again.
        go(P0 + 300);
        exp_ev(P0 + 306, S_RUN, 1'b0, 1'b0, 1'b0);
        exp_ticks(P0 + 306, P0 + 343);
        sw.btn_ss = 1'b1;
        go(P0 + 310); sw.btn_ss = 1'b0;
        go(P0 + 320);
        exp_ev(P0 + 326, S_LAP, 1'b0, 1'b1, 1'b1);
        sw.btn_lr = 1'b1;
        go(P0 + 330); sw.btn_lr = 1'b0;
        go(P0 + 343);

        n_chk++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events got %0d left want 0", evq.size());
        end
        n_chk++;
        if (tkq.size() != 0) begin
            n_fail++;
            $display("FAIL missing_cnt_en got %0d left want 0", tkq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
